demux_router: RTL and testbench

Two-way byte router: 8-bit input stream with valid/ready handshake, steered by `Control` into one of two output channels, each backed by its own small FIFO. It is the splitting counterpart to the 2:1 byte mux already in the datapath: the mux merges two byte sources onto one bus, and this block fans one bus back out to two consumers without losing bytes when a consumer stalls. A synchronous `Clear` flushes both channels, matching the mux's clear semantics.

---
 rtl/demux_router.sv | 103 ++++++++++
 tb/tb_demux_router.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// Two-way byte router: one valid/ready input stream is steered by Control into
// one of two independent FIFO channels so that a stall on one consumer never blocks the other.
module demux_router #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     Clear,
    input  logic                     Control,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [WIDTH-1:0]         out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   level0,
    output logic [$clog2(DEPTH):0]   level1
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [LW-1:0]    level  [2];

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] consumer_ready;
    logic       accept;

    assign consumer_ready = {out1_ready, out0_ready};

    always_comb begin
        full = '0;
        for (int n = 0; n < 2; n++) begin
            full[n] = (level[n] == LW'(DEPTH));
        end
    end

    // Readiness depends only on the selected channel's level, never on the pop side,
    // so a full channel refuses a byte even when its consumer drains that same cycle.
    assign in_ready = Reset_n & ~Clear & ~(Control ? full[1] : full[0]);
    assign accept   = in_valid & in_ready;
    assign push     = {accept & Control, accept & ~Control};

    always_comb begin
        pop = '0;
        for (int n = 0; n < 2; n++) begin
            pop[n] = (level[n] != '0) & consumer_ready[n];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                level[n]  <= '0;
            end
        end else if (Clear) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                level[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) wr_ptr[n] <= wr_ptr[n] + PW'(1);
                if (pop[n])  rd_ptr[n] <= rd_ptr[n] + PW'(1);
                case ({push[n], pop[n]})
                    2'b10:   level[n] <= level[n] + LW'(1);
                    2'b01:   level[n] <= level[n] - LW'(1);
                    default: level[n] <= level[n];
                endcase
            end
        end
    end

    // NOTE: storage has no reset; empty channels mask their data output to zero,
    // so stale entries are never visible and the array can map to plain registers/RAM.
    always_ff @(posedge Clock) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) mem[n][wr_ptr[n]] <= in_data;
        end
    end

    assign out0_valid = (level[0] != '0);
    assign out1_valid = (level[1] != '0);
    assign out0_data  = out0_valid ? mem[0][rd_ptr[0]] : '0;
    assign out1_data  = out1_valid ? mem[1][rd_ptr[1]] : '0;
    assign level0     = level[0];
    assign level1     = level[1];

endmodule

// File: tb/tb_demux_router.sv
// Directed self-checking bench for demux_router: routing, backpressure, channel
// independence, pointer wrap, synchronous clear and asynchronous reset.
module tb_demux_router;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             Clock;
    logic             Reset_n;
    logic             Clear;
    logic             Control;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [LW-1:0]    level0;
    logic [LW-1:0]    level1;

    int checks   = 0;
    int failures = 0;

    demux_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Clear      (Clear),
        .Control    (Control),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .level0     (level0),
        .level1     (level1)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        int max_level;
        logic acc;

        Reset_n = 1'b0; Clear = 1'b0; Control = 1'b0;
        in_data = '0; in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data", 32'(out0_data), 32'h0);
        check("rst_level0", 32'(level0), 32'd0);
        check("rst_level1", 32'(level1), 32'd0);
        #10;
        Reset_n = 1'b1;
        settle();
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Basic routing
        out0_ready = 1'b1; out1_ready = 1'b1;
        Control = 1'b0; in_data = 8'h11; in_valid = 1'b1;
        step();
        check("route_out0_valid", 32'(out0_valid), 32'd1);
        check("route_out0_data", 32'(out0_data), 32'h11);
        check("route_level0", 32'(level0), 32'd1);
        Control = 1'b1; in_data = 8'h22;
        step();
        check("route_out1_data", 32'(out1_data), 32'h22);
        check("route_level0_drained", 32'(level0), 32'd0);
        check("route_out0_empty_data", 32'(out0_data), 32'h0);
        in_valid = 1'b0;
        step();
        check("route_level1_drained", 32'(level1), 32'd0);

        // Fill and backpressure on channel 0
        out0_ready = 1'b0; Control = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 8'hA0 + 8'(i);
            settle();
            check("fill_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_data = 8'hA4;
        settle();
        check("fill_level0", 32'(level0), 32'd4);
        check("fill_in_ready_full", 32'(in_ready), 32'd0);
        step();
        check("fill_level0_hold", 32'(level0), 32'd4);
        check("fill_head", 32'(out0_data), 32'hA0);

        // Independence: channel 1 accepts while channel 0 is stalled and full
        Control = 1'b1; in_data = 8'h55;
        settle();
        check("indep_in_ready", 32'(in_ready), 32'd1);
        step();
        check("indep_out1_data", 32'(out1_data), 32'h55);
        check("indep_level1", 32'(level1), 32'd1);
        check("indep_level0", 32'(level0), 32'd4);
        check("indep_head0", 32'(out0_data), 32'hA0);
        in_valid = 1'b0; out1_ready = 1'b1;
        step();
        check("indep_level1_drained", 32'(level1), 32'd0);

        // Release channel 0; 0xA4 enters once a slot frees
        Control = 1'b0; in_data = 8'hA4; in_valid = 1'b1; out0_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("drain_valid", 32'(out0_valid), 32'd1);
            check("drain_order", 32'(out0_data), 32'hA0 + 32'(k));
            if (k == 0) check("drain_full_blocks", 32'(in_ready), 32'd0);
            acc = in_valid & in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        check("drain_level0", 32'(level0), 32'd0);
        check("drain_pushed_a4", 32'(in_valid), 32'd0);

        // Wrap-around: 16 bytes through channel 1 with toggling consumer
        Control = 1'b1; sent = 0; recv = 0; max_level = 0;
        for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
            out1_ready = cyc[0];
            in_valid = (sent < 16);
            in_data = 8'(sent);
            settle();
            if (out1_valid && out1_ready) begin
                check("wrap_order", 32'(out1_data), 32'(recv));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
            if (int'(level1) > max_level) max_level = int'(level1);
        end
        in_valid = 1'b0;
        check("wrap_all_received", 32'(recv), 32'd16);
        check("wrap_max_level_ok", 32'(max_level <= DEPTH), 32'd1);
        check("wrap_level1_end", 32'(level1), 32'd0);

        // Clear mid-stream
        out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
        Control = 1'b0;
        for (int i = 0; i < 3; i++) begin in_data = 8'hB0 + 8'(i); step(); end
        Control = 1'b1;
        for (int i = 0; i < 2; i++) begin in_data = 8'hC0 + 8'(i); step(); end
        check("clr_pre_level0", 32'(level0), 32'd3);
        check("clr_pre_level1", 32'(level1), 32'd2);
        Clear = 1'b1; Control = 1'b0; in_data = 8'hEE; out0_ready = 1'b1;
        settle();
        check("clr_in_ready", 32'(in_ready), 32'd0);
        step();
        Clear = 1'b0; in_valid = 1'b0; out0_ready = 1'b0;
        check("clr_level0", 32'(level0), 32'd0);
        check("clr_level1", 32'(level1), 32'd0);
        check("clr_out0_valid", 32'(out0_valid), 32'd0);
        check("clr_out1_valid", 32'(out1_valid), 32'd0);
        check("clr_out0_data", 32'(out0_data), 32'h0);
        in_data = 8'hDD; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("clr_post_level0", 32'(level0), 32'd1);
        check("clr_post_head", 32'(out0_data), 32'hDD);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        check("clr_post_drained", 32'(level0), 32'd0);

        // Asynchronous reset between edges
        in_valid = 1'b1; Control = 1'b0; in_data = 8'h31;
        step();
        Control = 1'b1; in_data = 8'h32;
        step();
        in_valid = 1'b0;
        check("arst_pre_level0", 32'(level0), 32'd1);
        check("arst_pre_level1", 32'(level1), 32'd1);
        @(negedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("arst_out0_valid", 32'(out0_valid), 32'd0);
        check("arst_out1_valid", 32'(out1_valid), 32'd0);
        check("arst_out0_data", 32'(out0_data), 32'h0);
        check("arst_out1_data", 32'(out1_data), 32'h0);
        check("arst_level0", 32'(level0), 32'd0);
        check("arst_level1", 32'(level1), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge Clock);
        Reset_n = 1'b1;
        settle();
        check("arst_release_in_ready", 32'(in_ready), 32'd1);
        Control = 1'b1; in_data = 8'h44; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("arst_post_out1_data", 32'(out1_data), 32'h44);
        check("arst_post_level1", 32'(level1), 32'd1);
        check("arst_post_level0", 32'(level0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
